// File: rtl/dram_ctrl_seq.sv
// dram_ctrl_seq
// Sequences the off-chip DRAM on behalf of the on-chip DRAM slave. It accepts
// one word request at a time and issues ACT/RD/WR/PRE commands with
// programmable spacing. The row stays open after an access, so a later access
// to the same row skips the ACT. Read data or a write completion goes back on a
// valid/ready response channel.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_write, req_addr[20:0]     1=write; word address row=[20:10], col=[9:0]
//   req_wdata[31:0], req_wstrb    write data and active-high byte enables
//   rsp_valid/rsp_ready           response handshake, held until accepted
//   rsp_write, rsp_rdata[31:0]    1=write completion, read data (0 for writes)
//   DRAM_CSn/RASn/CASn/WEn[3:0]   active-low command pins
//   DRAM_A[10:0], DRAM_D[31:0]    address (row or {0,col}) and write data
//   DRAM_Q[31:0], DRAM_valid      read data returned by the DRAM
module dram_ctrl_seq #(
    parameter int T_RCD = 5,
    parameter int T_RP  = 5,
    parameter int T_WR  = 5,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [20:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic        DRAM_CSn,
    output logic        DRAM_RASn,
    output logic        DRAM_CASn,
    output logic [3:0]  DRAM_WEn,
    output logic [10:0] DRAM_A,
    output logic [31:0] DRAM_D,
    input  logic [31:0] DRAM_Q,
    input  logic        DRAM_valid
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_PRE   = 4'd1;
    localparam logic [3:0] S_PRE_W = 4'd2;
    localparam logic [3:0] S_ACT   = 4'd3;
    localparam logic [3:0] S_ACT_W = 4'd4;
    localparam logic [3:0] S_CAS   = 4'd5;
    localparam logic [3:0] S_RD_W  = 4'd6;
    localparam logic [3:0] S_WR_W  = 4'd7;
    localparam logic [3:0] S_RSP   = 4'd8;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rowOpen_q, rowOpen_d;
    logic [10:0]      openRow_q, openRow_d;
    logic             write_q, write_d;
    logic [20:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             started_q, started_d;
    logic             csn_q, csn_d, rasn_q, rasn_d, casn_q, casn_d;
    logic [3:0]       wen_q, wen_d;
    logic [10:0]      a_q, a_d;
    logic [31:0]      d_q, d_d;
    logic             reqReady_q, reqReady_d;
    logic             rspValid_q, rspValid_d;
    logic             rspWrite_q, rspWrite_d;
    logic [31:0]      rspRdata_q, rspRdata_d;
    logic             accept;

    assign accept = req_valid && reqReady_q;

    // Next-state, timing counter and request latch. Every command output is
    // computed from the state being entered so the registered pins show the
    // command during the first cycle of that state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        rowOpen_d  = rowOpen_q;
        openRow_d  = openRow_q;
        write_d    = accept ? req_write : write_q;
        addr_d     = accept ? req_addr  : addr_q;
        wdata_d    = accept ? req_wdata : wdata_q;
        wstrb_d    = accept ? req_wstrb : wstrb_q;
        started_d  = started_q | accept;
        rspWrite_d = rspWrite_q;
        rspRdata_d = rspRdata_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (rowOpen_q && (req_addr[20:10] == openRow_q)) state_d = S_CAS;
                    else if (rowOpen_q)                             state_d = S_PRE;
                    else                                            state_d = S_ACT;
                end
            end
            S_PRE, S_PRE_W: state_d = (cnt_q == '0) ? S_ACT : S_PRE_W;
            S_ACT, S_ACT_W: state_d = (cnt_q == '0) ? S_CAS : S_ACT_W;
            S_CAS: begin
                if (!write_q)              state_d = S_RD_W;
                else if (wstrb_q == 4'h0)  state_d = S_RSP;
                else if (cnt_q == '0)      state_d = S_RSP;
                else                       state_d = S_WR_W;
            end
            S_RD_W: if (DRAM_valid) state_d = S_RSP;
            S_WR_W: if (cnt_q == '0) state_d = S_RSP;
            S_RSP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The single-cycle command states load the wait that follows them.
        if (state_d != state_q) begin
            case (state_d)
                S_PRE:   cnt_d = CNT_W'(T_RP - 1);
                S_ACT:   cnt_d = CNT_W'(T_RCD - 1);
                S_CAS:   cnt_d = CNT_W'(T_WR - 1);
                default: ;
            endcase
        end

        if (state_d == S_PRE) rowOpen_d = 1'b0;
        if (state_d == S_ACT) begin
            rowOpen_d = 1'b1;
            openRow_d = addr_d[20:10];
        end

        // Entering RSP captures the read word, or zero for a write completion.
        if ((state_d == S_RSP) && (state_q != S_RSP)) begin
            rspWrite_d = write_q;
            rspRdata_d = write_q ? 32'h0 : DRAM_Q;
        end
        rspValid_d = (state_d == S_RSP);
        reqReady_d = (state_d == S_IDLE);
    end

    // DRAM pin values for the cycle being entered. Anything that is not a real
    // command is a NOP; the chip stays deselected until the first request.
    always_comb begin
        csn_d  = ~started_d;
        rasn_d = 1'b1;
        casn_d = 1'b1;
        wen_d  = 4'hF;
        a_d    = a_q;
        d_d    = d_q;
        case (state_d)
            S_PRE: begin
                csn_d  = 1'b0;
                rasn_d = 1'b0;
                wen_d  = 4'h0;
            end
            S_ACT: begin
                csn_d  = 1'b0;
                rasn_d = 1'b0;
                a_d    = addr_d[20:10];
            end
            S_CAS: begin
                if (!write_d) begin
                    csn_d  = 1'b0;
                    casn_d = 1'b0;
                    a_d    = {1'b0, addr_d[9:0]};
                end else if (wstrb_d != 4'h0) begin
                    csn_d  = 1'b0;
                    casn_d = 1'b0;
                    wen_d  = ~wstrb_d;
                    a_d    = {1'b0, addr_d[9:0]};
                    d_d    = wdata_d;
                end
            end
            default: ;
        endcase
    end

    // All state and every output pin is registered; reset abandons any
    // sequence in flight and forgets the open row.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rowOpen_q  <= 1'b0;
            openRow_q  <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            started_q  <= 1'b0;
            csn_q      <= 1'b1;
            rasn_q     <= 1'b1;
            casn_q     <= 1'b1;
            wen_q      <= 4'hF;
            a_q        <= '0;
            d_q        <= '0;
            reqReady_q <= 1'b0;
            rspValid_q <= 1'b0;
            rspWrite_q <= 1'b0;
            rspRdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rowOpen_q  <= rowOpen_d;
            openRow_q  <= openRow_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            started_q  <= started_d;
            csn_q      <= csn_d;
            rasn_q     <= rasn_d;
            casn_q     <= casn_d;
            wen_q      <= wen_d;
            a_q        <= a_d;
            d_q        <= d_d;
            reqReady_q <= reqReady_d;
            rspValid_q <= rspValid_d;
            rspWrite_q <= rspWrite_d;
            rspRdata_q <= rspRdata_d;
        end
    end

    assign req_ready = reqReady_q;
    assign rsp_valid = rspValid_q;
    assign rsp_write = rspWrite_q;
    assign rsp_rdata = rspRdata_q;
    assign DRAM_CSn  = csn_q;
    assign DRAM_RASn = rasn_q;
    assign DRAM_CASn = casn_q;
    assign DRAM_WEn  = wen_q;
    assign DRAM_A    = a_q;
    assign DRAM_D    = d_q;

endmodule

// File: tb/tb_dram_ctrl_seq.sv
// tb_dram_ctrl_seq
// Directed bench for dram_ctrl_seq with default timing (T_RCD=T_RP=T_WR=5).
// A small DRAM model decodes the command pins, keeps a sparse memory whose
// unwritten words read as 0xA5000000|address, and returns read data two
// cycles after each RD. Expected values below are worked out by hand.
module tb_dram_ctrl_seq;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [20:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic        DRAM_CSn, DRAM_RASn, DRAM_CASn;
    logic [3:0]  DRAM_WEn;
    logic [10:0] DRAM_A;
    logic [31:0] DRAM_D, DRAM_Q;
    logic        DRAM_valid;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int actCount = 0, preCount = 0, rdCount = 0, wrCount = 0, cmdCount = 0;
    int lastActCycle = 0, lastPreCycle = 0, lastRdCycle = 0, lastWrCycle = 0;
    logic [10:0] lastActA, lastRdA, lastWrA, modelRow;
    logic [3:0]  lastWen;
    logic [31:0] lastD;
    int pend = 0;
    logic [31:0] pendData;
    logic [31:0] mem [int];

    int acceptCyc, rspCyc;

    dram_ctrl_seq dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .DRAM_CSn(DRAM_CSn), .DRAM_RASn(DRAM_RASn), .DRAM_CASn(DRAM_CASn),
        .DRAM_WEn(DRAM_WEn), .DRAM_A(DRAM_A), .DRAM_D(DRAM_D),
        .DRAM_Q(DRAM_Q), .DRAM_valid(DRAM_valid)
    );

    // Free-running clock and a cycle counter bumped on every rising edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] memRead(input int a);
        if (mem.exists(a)) return mem[a];
        return 32'hA5000000 | 32'(a);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // DRAM model: watches the pins mid-cycle, records each command and
    // answers reads two cycles after the RD, with junk on DRAM_Q otherwise.
    initial begin
        DRAM_valid = 1'b0;
        DRAM_Q     = 32'hBAD0BAD0;
        modelRow   = '0;
        forever begin
            @(negedge clk);
            DRAM_valid = 1'b0;
            DRAM_Q     = 32'hBAD0BAD0;
            if (pend == 1) begin
                DRAM_valid = 1'b1;
                DRAM_Q     = pendData;
            end
            if (pend > 0) pend--;
            if (!DRAM_CSn && !(DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'hF)) begin
                cmdCount++;
                if (!DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'hF) begin
                    actCount++; lastActCycle = cyc; lastActA = DRAM_A; modelRow = DRAM_A;
                end else if (!DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'h0) begin
                    preCount++; lastPreCycle = cyc;
                end else if (DRAM_RASn && !DRAM_CASn && DRAM_WEn == 4'hF) begin
                    rdCount++; lastRdCycle = cyc; lastRdA = DRAM_A;
                    pend = 2;
                    pendData = memRead(int'({modelRow, DRAM_A[9:0]}));
                end else if (DRAM_RASn && !DRAM_CASn) begin
                    logic [31:0] cur;
                    int a;
                    wrCount++; lastWrCycle = cyc; lastWrA = DRAM_A;
                    lastWen = DRAM_WEn; lastD = DRAM_D;
                    a = int'({modelRow, DRAM_A[9:0]});
                    cur = memRead(a);
                    for (int b = 0; b < 4; b++)
                        if (!DRAM_WEn[b]) cur[8*b +: 8] = DRAM_D[8*b +: 8];
                    mem[a] = cur;
                end
            end
        end
    end

    // Presents one request at a negedge and holds it until it is accepted;
    // acceptCyc is the cycle whose closing edge takes the request.
    task automatic applyStimulus(input logic wr, input logic [20:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb);
        int n;
        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_wdata = wdata; req_wstrb = wstrb;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) checkOutput("accept_timeout", 32'(req_ready), 32'd1);
        acceptCyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic waitRsp(input string tag);
        int n;
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        rspCyc = cyc;
        if (!rsp_valid) checkOutput({tag, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic ackRsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput({tag, "_ready_after_rsp"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int actBefore, preBefore, wrBefore, cmdBefore;
        logic stable;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b0;

        // Reset held for three edges.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_csn",   32'(DRAM_CSn),  32'd1);
        checkOutput("rst_rasn",  32'(DRAM_RASn), 32'd1);
        checkOutput("rst_casn",  32'(DRAM_CASn), 32'd1);
        checkOutput("rst_wen",   32'(DRAM_WEn),  32'hF);
        checkOutput("rst_a",     32'(DRAM_A),    32'd0);
        checkOutput("rst_d",     DRAM_D,         32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp",   32'({rsp_valid, rsp_write}), 32'd0);
        checkOutput("rst_rdata", rsp_rdata,      32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_first_idle", 32'(req_ready), 32'd1);
        checkOutput("csn_before_req",   32'(DRAM_CSn),  32'd1);

        // Cold read of row 3, col 5.
        applyStimulus(1'b0, 21'h00C05, 32'h0, 4'h0);
        waitRsp("cold");
        checkOutput("cold_act_cycle", 32'(lastActCycle - acceptCyc), 32'd1);
        checkOutput("cold_act_a",     32'(lastActA), 32'd3);
        checkOutput("cold_rd_cycle",  32'(lastRdCycle - acceptCyc), 32'd6);
        checkOutput("cold_rd_a",      32'(lastRdA), 32'd5);
        checkOutput("cold_rsp_cycle", 32'(rspCyc - lastRdCycle), 32'd3);
        checkOutput("cold_rdata",     rsp_rdata, 32'hA5000C05);
        checkOutput("cold_rsp_write", 32'(rsp_write), 32'd0);
        checkOutput("nop_pins", 32'({DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn}), 32'h3F);
        ackRsp("cold");

        // Row-hit write with bytes 0 and 2 enabled.
        actBefore = actCount; preBefore = preCount;
        applyStimulus(1'b1, 21'h00C06, 32'hDEADBEEF, 4'b0101);
        waitRsp("wr");
        checkOutput("wr_no_act",     32'(actCount - actBefore), 32'd0);
        checkOutput("wr_no_pre",     32'(preCount - preBefore), 32'd0);
        checkOutput("wr_cycle",      32'(lastWrCycle - acceptCyc), 32'd1);
        checkOutput("wr_a",          32'(lastWrA), 32'd6);
        checkOutput("wr_wen",        32'(lastWen), 32'hA);
        checkOutput("wr_d",          lastD, 32'hDEADBEEF);
        checkOutput("wr_rsp_cycle",  32'(rspCyc - lastWrCycle), 32'd5);
        checkOutput("wr_rsp_write",  32'(rsp_write), 32'd1);
        checkOutput("wr_rsp_rdata",  rsp_rdata, 32'd0);
        ackRsp("wr");

        // Row miss: read row 7, col 0x10 while row 3 is open.
        applyStimulus(1'b0, 21'h01C10, 32'h0, 4'h0);
        waitRsp("miss");
        checkOutput("miss_pre_cycle", 32'(lastPreCycle - acceptCyc), 32'd1);
        checkOutput("miss_act_gap",   32'(lastActCycle - lastPreCycle), 32'd5);
        checkOutput("miss_act_a",     32'(lastActA), 32'd7);
        checkOutput("miss_rd_gap",    32'(lastRdCycle - lastActCycle), 32'd5);
        checkOutput("miss_rdata",     rsp_rdata, 32'hA5001C10);
        ackRsp("miss");

        // Readback of the masked write, holding off the response for 10 cycles.
        applyStimulus(1'b0, 21'h00C06, 32'h0, 4'h0);
        waitRsp("rb");
        cmdBefore = cmdCount;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== 32'hA5AD0CEF || req_ready) stable = 1'b0;
        end
        checkOutput("hold_stable",  32'(stable), 32'd1);
        checkOutput("hold_no_cmd",  32'(cmdCount - cmdBefore), 32'd0);
        checkOutput("rb_rdata",     rsp_rdata, 32'hA5AD0CEF);
        ackRsp("rb");

        // Write with no byte enables on the open row: no WR, quick completion.
        wrBefore = wrCount;
        applyStimulus(1'b1, 21'h00C07, 32'h12345678, 4'h0);
        waitRsp("nostrb");
        checkOutput("nostrb_no_wr",     32'(wrCount - wrBefore), 32'd0);
        checkOutput("nostrb_rsp_cycle", 32'(rspCyc - acceptCyc), 32'd2);
        checkOutput("nostrb_rsp_write", 32'(rsp_write), 32'd1);
        ackRsp("nostrb");

        // Reset in ACT_W: row 9 miss, ACT lands at accept+6, reset at accept+8.
        applyStimulus(1'b0, 21'h02400, 32'h0, 4'h0);
        repeat (7) @(negedge clk);
        checkOutput("abort_act_seen", 32'(lastActCycle - acceptCyc), 32'd6);
        checkOutput("abort_act_a",    32'(lastActA), 32'd9);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_pins", 32'({DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn}), 32'h7F);
        checkOutput("abort_a",    32'(DRAM_A), 32'd0);
        checkOutput("abort_hs",   32'({req_ready, rsp_valid}), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort_no_rsp", 32'(rsp_valid), 32'd0);
        actBefore = actCount; preBefore = preCount;
        applyStimulus(1'b0, 21'h02401, 32'h0, 4'h0);
        waitRsp("reopen");
        checkOutput("reopen_act",       32'(actCount - actBefore), 32'd1);
        checkOutput("reopen_no_pre",    32'(preCount - preBefore), 32'd0);
        checkOutput("reopen_act_cycle", 32'(lastActCycle - acceptCyc), 32'd1);
        checkOutput("reopen_rdata",     rsp_rdata, 32'hA5002401);
        ackRsp("reopen");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
